// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb
//   Write-back arbiter and scoreboard for the 31-entry integer register file
//   (x0 hard-wired to zero). Two write-back sources, A (execute) and B (load),
//   share the single register-file write port under round-robin arbitration.
//   A busy bit per register tracks writes that are issued but not yet
//   committed, so the issue stage can stall on RAW and WAW hazards.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   a_valid/a_ready/a_rd/a_data  write-back source A (ready = granted)
//   b_valid/b_ready/b_rd/b_data  write-back source B (ready = granted)
//   iss_valid, iss_rd            issuing instruction and its destination
//   iss_ready                    issue accepted (destination not busy)
//   rs1_addr/rs2_addr            source-register queries
//   rs1_busy/rs2_busy            queried register has a write outstanding
//   rf_we/rf_waddr/rf_wdata      registered register-file write port
//
// Build option
//   WB_BYPASS_EN  adds rs1_fwd, rs2_fwd and fwd_data. A register being
//                 written this cycle reads as not busy and is flagged for
//                 forwarding from rf_wdata.

module regfile_wb_arb #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
`ifdef WB_BYPASS_EN
    ,
    output logic            rs1_fwd,
    output logic            rs2_fwd,
    output logic [XLEN-1:0] fwd_data
`endif
);

    // Source granted most recently. It loses the next tie.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    src_e            last_q, last_d;
    logic [31:0]     busy_q, busy_d;
    logic [31:0]     busy_set, busy_clr;
    logic            grant;
    logic [4:0]      grant_rd;
    logic [XLEN-1:0] grant_data;

    // Round-robin grant. It depends only on the valids and the pointer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        a_ready = 1'b0;
        b_ready = 1'b0;
        last_d  = last_q;
        if (a_valid && b_valid) begin
            if (last_q == SRC_B) a_ready = 1'b1;
            else                 b_ready = 1'b1;
        end else begin
            a_ready = a_valid;
            b_ready = b_valid;
        end
        if (a_ready)      last_d = SRC_A;
        else if (b_ready) last_d = SRC_B;
    end

    assign grant      = a_ready | b_ready;
    assign grant_rd   = a_ready ? a_rd   : b_rd;
    assign grant_data = a_ready ? a_data : b_data;

    // Scoreboard. Bit 0 is kept at zero, so x0 never reads as busy.
    assign iss_ready = (iss_rd == 5'd0) || !busy_q[iss_rd];

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_valid && iss_ready && (iss_rd != 5'd0)) busy_set[iss_rd] = 1'b1;
        if (rf_we) busy_clr[rf_waddr] = 1'b1;
        // The set is applied after the clear, so it wins when both hit one bit.
        busy_d    = (busy_q & ~busy_clr) | busy_set;
        busy_d[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    logic rs1_hit, rs2_hit;

    assign rs1_hit  = rf_we && (rf_waddr == rs1_addr);
    assign rs2_hit  = rf_we && (rf_waddr == rs2_addr);
    assign rs1_busy = busy_q[rs1_addr] && !rs1_hit;
    assign rs2_busy = busy_q[rs2_addr] && !rs2_hit;
    assign rs1_fwd  = rs1_hit;
    assign rs2_fwd  = rs2_hit;
    assign fwd_data = rf_wdata;
`else
    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];
`endif

    // NOTE: state registers use non-blocking assignments only, so every
    // flop samples the pre-edge values whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the scoreboard is a flop vector, not a RAM, and it must
            // reset. Stale busy bits would deadlock issue after a reset.
            last_q   <= SRC_B;
            busy_q   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            last_q <= last_d;
            busy_q <= busy_d;
            // A grant to x0 is consumed but produces no write.
            rf_we  <= grant && (grant_rd != 5'd0);
            if (grant) begin
                rf_waddr <= grant_rd;
                rf_wdata <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb
//   Self-checking bench for regfile_wb_arb. It applies a table of directed
//   vectors, then hand-written multi-cycle sequences (WAW stall, reset during
//   a write, read in the cycle after a grant). It finishes with randomized
//   traffic checked against a behavioural scoreboard model.
//   Build with WB_BYPASS_EN defined to exercise the forward ports.

module tb_regfile_wb_arb;

    localparam int XLEN = 64;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, a_ready, b_valid, b_ready;
    logic [4:0]      a_rd, b_rd;
    logic [XLEN-1:0] a_data, b_data;
    logic            iss_valid, iss_ready;
    logic [4:0]      iss_rd, rs1_addr, rs2_addr;
    logic            rs1_busy, rs2_busy;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
`ifdef WB_BYPASS_EN
    logic            rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] fwd_data;
`endif

    regfile_wb_arb #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_BYPASS_EN
        ,
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        iss_valid = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic        av;  logic [4:0] ard; logic [63:0] ad;
        logic        bv;  logic [4:0] brd; logic [63:0] bd;
        logic        iv;  logic [4:0] ird;
        logic [4:0]  r1;  logic [4:0] r2;
        logic        e_ar, e_br, e_ir, e_b1, e_b2, e_we;
        logic [4:0]  e_wa; logic [63:0] e_wd;
    } vec_t;

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [63:0] ad,
        input logic bv, input logic [4:0] brd, input logic [63:0] bd,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic e_ar, input logic e_br, input logic e_ir,
        input logic e_b1, input logic e_b2,
        input logic e_we, input logic [4:0] e_wa, input logic [63:0] e_wd);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.bv = bv; v.brd = brd; v.bd = bd;
        v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
        v.e_ar = e_ar; v.e_br = e_br; v.e_ir = e_ir; v.e_b1 = e_b1; v.e_b2 = e_b2;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        return v;
    endfunction

    vec_t vecs[13];

    // Behavioural model state for the random phase.
    bit          sb[32];
    int          last_w;          // 1 = A, 2 = B
    bit          inf_we;
    logic [4:0]  inf_addr;
    logic [63:0] inf_data;
    bit          ah, bh;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Each row covers one cycle. Ready and busy are expected in that cycle;
        // rf_* reflect the grant of the previous row.
        vecs[0]  = mk(0,0,0,      0,0,0,      0,5, 5,0, 0,0,1,0,0,    0,0,0);
        vecs[1]  = mk(0,0,0,      0,0,0,      1,5, 5,0, 0,0,1,0,0,    0,0,0);
        vecs[2]  = mk(1,5,'hDEAD, 0,0,0,      0,5, 5,5, 1,0,0,1,1,    0,0,0);
        vecs[3]  = mk(0,0,0,      0,0,0,      0,5, 5,0, 0,0,0,!BYP,0, 1,5,'hDEAD);
        vecs[4]  = mk(0,0,0,      0,0,0,      0,5, 5,0, 0,0,1,0,0,    0,0,0);
        vecs[5]  = mk(0,0,0,      1,0,'h55,   1,0, 5,0, 0,1,1,0,0,    0,0,0);
        vecs[6]  = mk(1,1,'h11,   1,2,'h22,   0,0, 0,1, 1,0,1,0,0,    0,0,0);
        vecs[7]  = mk(1,1,'h13,   1,2,'h22,   0,0, 1,2, 0,1,1,0,0,    1,1,'h11);
        vecs[8]  = mk(1,1,'h13,   1,2,'h24,   0,0, 1,2, 1,0,1,0,0,    1,2,'h22);
        vecs[9]  = mk(1,1,'h15,   1,2,'h24,   0,0, 1,2, 0,1,1,0,0,    1,1,'h13);
        vecs[10] = mk(1,1,'h15,   0,0,0,      0,0, 0,0, 1,0,1,0,0,    1,2,'h24);
        vecs[11] = mk(0,0,0,      0,0,0,      0,0, 5,0, 0,0,1,0,0,    1,1,'h15);
        vecs[12] = mk(0,0,0,      0,0,0,      0,0, 5,0, 0,0,1,0,0,    0,0,0);

        // ---------------- directed table ----------------
        do_reset();
        for (int i = 0; i < 13; i++) begin
            a_valid = vecs[i].av; a_rd = vecs[i].ard; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_rd = vecs[i].brd; b_data = vecs[i].bd;
            iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
            rs1_addr = vecs[i].r1; rs2_addr = vecs[i].r2;
            #1;
            check($sformatf("vec%0d a_ready", i),   a_ready,   vecs[i].e_ar);
            check($sformatf("vec%0d b_ready", i),   b_ready,   vecs[i].e_br);
            check($sformatf("vec%0d iss_ready", i), iss_ready, vecs[i].e_ir);
            check($sformatf("vec%0d rs1_busy", i),  rs1_busy,  vecs[i].e_b1);
            check($sformatf("vec%0d rs2_busy", i),  rs2_busy,  vecs[i].e_b2);
            check($sformatf("vec%0d rf_we", i),     rf_we,     vecs[i].e_we);
            if (i == 0 || vecs[i].e_we) begin
                check($sformatf("vec%0d rf_waddr", i), rf_waddr, vecs[i].e_wa);
                check($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].e_wd);
            end
            tick();
        end

        // ---------------- WAW stall on x7 ----------------
        idle(); iss_valid = 1; iss_rd = 7; #1;
        check("waw first issue", iss_ready, 1);
        tick();
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("waw stall %0d", c), iss_ready, 0);
            tick();
        end
        a_valid = 1; a_rd = 7; a_data = 'h77; #1;
        check("waw grant a_ready", a_ready, 1);
        check("waw stall at grant", iss_ready, 0);
        tick();
        a_valid = 0; #1;
        check("waw stall at write", iss_ready, 0);
        check("waw rf_we", rf_we, 1);
        check("waw rf_waddr", rf_waddr, 7);
        tick();
        #1 check("waw released", iss_ready, 1);
        tick();
        iss_valid = 0; rs1_addr = 7; #1;
        check("waw reissue busy", rs1_busy, 1);

        // ---------------- reset during a write ----------------
        do_reset();
        iss_valid = 1; iss_rd = 3; tick();
        iss_rd = 9; b_valid = 1; b_rd = 3; b_data = 'hAB; #1;
        check("rst seq b_ready", b_ready, 1);
        tick();
        idle(); rs1_addr = 3; rs2_addr = 9; iss_rd = 9; #1;
        check("rst seq rf_we before", rf_we, 1);
        check("rst seq x9 busy before", rs2_busy, 1);
        rst = 1'b1; #1;
        check("rst seq rf_we dropped", rf_we, 0);
        check("rst seq x3 cleared", rs1_busy, 0);
        check("rst seq x9 cleared", rs2_busy, 0);
        check("rst seq iss_ready", iss_ready, 1);
        tick();
        rst = 1'b0;

        // ---------------- read in the cycle after a grant ----------------
        idle(); iss_valid = 1; iss_rd = 9; tick();
        idle(); a_valid = 1; a_rd = 9; a_data = 'h1234; rs2_addr = 9; #1;
        check("byp busy at grant", rs2_busy, 1);
        tick();
        idle(); rs2_addr = 9; #1;
        check("byp rs2_busy N+1", rs2_busy, !BYP);
        check("byp rf_wdata", rf_wdata, 'h1234);
`ifdef WB_BYPASS_EN
        check("byp rs2_fwd", rs2_fwd, 1);
        check("byp fwd_data", fwd_data, 'h1234);
        check("byp rs1_fwd off", rs1_fwd, 0);
`endif
        tick();
        #1 check("byp rs2_busy N+2", rs2_busy, 0);

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        foreach (sb[k]) sb[k] = 0;
        last_w = 2; inf_we = 0; inf_addr = 0; inf_data = 0; ah = 0; bh = 0;
        for (int c = 0; c < 400; c++) begin
            int  win;
            bit  exp_ir, exp_b1, exp_b2;
            if (!ah) begin
                a_valid = ($urandom_range(0, 9) < 6);
                a_rd    = 5'($urandom_range(0, 7));
                a_data  = {$urandom, $urandom};
            end
            if (!bh) begin
                b_valid = ($urandom_range(0, 9) < 6);
                b_rd    = 5'($urandom_range(0, 7));
                b_data  = {$urandom, $urandom};
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = 5'($urandom_range(0, 7));
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 7));
            #1;
            if (a_valid && b_valid) win = (last_w == 1) ? 2 : 1;
            else if (a_valid)       win = 1;
            else if (b_valid)       win = 2;
            else                    win = 0;
            exp_ir = (iss_rd == 0) || !sb[iss_rd];
            exp_b1 = (rs1_addr != 0) && sb[rs1_addr] && !(BYP && inf_we && inf_addr == rs1_addr);
            exp_b2 = (rs2_addr != 0) && sb[rs2_addr] && !(BYP && inf_we && inf_addr == rs2_addr);
            check($sformatf("rnd%0d a_ready", c),   a_ready,   win == 1);
            check($sformatf("rnd%0d b_ready", c),   b_ready,   win == 2);
            check($sformatf("rnd%0d iss_ready", c), iss_ready, exp_ir);
            check($sformatf("rnd%0d rs1_busy", c),  rs1_busy,  exp_b1);
            check($sformatf("rnd%0d rs2_busy", c),  rs2_busy,  exp_b2);
            check($sformatf("rnd%0d rf_we", c),     rf_we,     inf_we);
            if (inf_we) begin
                check($sformatf("rnd%0d rf_waddr", c), rf_waddr, inf_addr);
                check($sformatf("rnd%0d rf_wdata", c), rf_wdata, inf_data);
            end
`ifdef WB_BYPASS_EN
            check($sformatf("rnd%0d rs1_fwd", c), rs1_fwd, inf_we && inf_addr == rs1_addr);
            if (inf_we) check($sformatf("rnd%0d fwd_data", c), fwd_data, inf_data);
`endif
            // Apply the edge: the commit clears, then the issue sets.
            if (inf_we) sb[inf_addr] = 0;
            if (iss_valid && exp_ir && iss_rd != 0) sb[iss_rd] = 1;
            if (win == 1) begin
                inf_we = (a_rd != 0); inf_addr = a_rd; inf_data = a_data;
            end else if (win == 2) begin
                inf_we = (b_rd != 0); inf_addr = b_rd; inf_data = b_data;
            end else begin
                inf_we = 0;
            end
            if (win != 0) last_w = win;
            ah = a_valid && (win != 1);
            bh = b_valid && (win != 2);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-back arbiter and scoreboard for the 31-entry, 64-bit integer register file (x0 hard-wired to zero). It shares the register file's single write port between two write-back sources, A (execute/ALU) and B (memory/load), using round-robin arbitration. It also tracks destinations that are issued but not yet written, so the issue stage can stall on RAW and WAW hazards. It sits between the pipeline back-end and the register file's `we/write_addr/write_data` port.

## Interface
Parameters:
- `XLEN`, 64, data width of the write-back path.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `a_valid` in 1: source A has a write pending.
- `a_ready` out 1: source A is granted this cycle.
- `a_rd` in 5: source A destination register.
- `a_data` in XLEN: source A write data.
- `b_valid`, `b_ready`, `b_rd`, `b_data`: the same signals for source B.
- `iss_valid` in 1: the issue stage wants to issue an instruction writing `iss_rd`.
- `iss_rd` in 5: destination register of the issuing instruction.
- `iss_ready` out 1: issue is accepted (no WAW hazard).
- `rs1_addr`, `rs2_addr` in 5: source-register queries.
- `rs1_busy`, `rs2_busy` out 1: the queried register has a write outstanding.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out XLEN: register-file write data.

## Operation
- **Scoreboard:** `busy[31:1]`; x0 is never busy.
  - `iss_ready = !busy[iss_rd]`, or 1 when `iss_rd == 0`.
  - On `iss_valid && iss_ready && iss_rd != 0`, set `busy[iss_rd]` at the clock edge.
- **Handshake:** a transfer occurs when `x_valid && x_ready`.
  - `x_ready` is combinational from the valids and the round-robin pointer; it does not depend on `rf_*`.
  - A source holds `rd` and `data` stable while valid and not ready.
- **Arbitration:**
  - One valid source: that source is granted.
  - Both valid: the source not granted most recently wins.
  - `last` updates only on a grant.
  - After reset `last = B`, so A wins the first tie.
  - At most one `x_ready` is high per cycle.
- **Write stage:** the granted `rd` and `data` are registered into `rf_waddr` and `rf_wdata`.
  - `rf_we <= grant && rd != 0`.
  - A grant with `rd == 0` is consumed and produces no write.
- **Scoreboard clear:** `busy[rf_waddr]` clears at the edge where `rf_we == 1`, i.e. the same edge at which the register file captures the data.
- **Simultaneous set and clear of the same rd:** this cannot occur, because issue is blocked while the register is busy. If it does occur, set wins.
- **Query outputs:** `rsN_busy = busy[rsN_addr]`, and 0 for x0.
- **Unsolicited writes:** a write to a register that is not busy is still performed, and the scoreboard is unaffected.

## Timing
- **Reset values:** `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `busy=0`, `last=B`.
  - Therefore `iss_ready=1`, `rs1_busy=0`, `rs2_busy=0` after reset.
  - `a_ready` and `b_ready` follow the valids.
- **Grant to write:** grant in cycle N; `rf_we` is high in cycle N+1; the register file updates at the end of N+1.
- **Busy deassertion:** `busy` is deasserted from cycle N+2 (without bypass).
- **Throughput:** one write per cycle. Under continuous contention the grant alternates A, B, A, B.
- **Reset mid-operation:** any pending write in the `rf_*` stage is dropped and all busy bits clear. Sources must re-present afterwards.

## Configuration
- **`WB_BYPASS_EN` defined:**
  - `rsN_busy` is forced to 0 in any cycle where `rf_we && rf_waddr == rsN_addr`.
  - Added outputs: `rs1_fwd` and `rs2_fwd` (1 bit) flag that case; `fwd_data` (XLEN) equals `rf_wdata`.
  - Effect: a dependent instruction may read in cycle N+1 via the forward path.
- **Not defined:** no forward ports. `rsN_busy` stays high through cycle N+1.

## Test plan
- **Reset and single issue:** reset, then issue `rd=5` → `busy[5]=1`, `rs1_busy=1` for `rs1_addr=5`. A grant with `rd=5`, data `0xDEAD` → `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEAD` one cycle later; `rs1_busy=0` the cycle after.
- **WAW stall:** issue `rd=7`, then present `iss_valid`, `rd=7` again → `iss_ready=0` until x7's write commits, then 1.
- **Contention:** `a_valid` and `b_valid` both held with `rd` = 1, 2 for 4 cycles → grants A, B, A, B; `rf_waddr` sequence 1, 2, 1, 2.
- **x0 write:** B valid with `rd=0`, data `0x55` → `b_ready=1`, `rf_we` stays 0, `busy` unchanged. Issue of `rd=0` → `iss_ready=1`, no busy bit set.
- **Reset mid-write:** assert `rst` in the cycle `rf_we=1` → `rf_we=0` immediately and all `busy` bits 0.
- **Bypass (`WB_BYPASS_EN`):** x9 busy, grant `rd=9` data `0x1234`, query `rs2_addr=9` in cycle N+1 → `rs2_busy=0`, `rs2_fwd=1`, `fwd_data=0x1234`.
